// File: rtl/piso_shifter.sv
// Parallel-in, serial-out shifter: takes a WIDTH-bit word on a load/ready handshake
// and emits it one bit per enabled clock with valid, start- and end-of-frame markers.
module piso_shifter #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    input  logic             en,
    output logic             q,
    output logic             q_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic [CW-1:0]    cnt, cnt_n, cnt_inc;
    logic             q_n, q_valid_n, sof_n, eof_n, busy_n;
    logic             last, accept;

    // First bit goes straight to q; the shift register keeps the rest,
    // with the next bit to send always at the exit end.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign last    = (cnt == CNT_LAST);
    assign cnt_inc = cnt + CW'(1);
    assign ready   = !rst && ((state == IDLE) || ((state == SHIFT) && last && en));
    assign accept  = load && ready;

    always_comb begin
        state_n   = state;
        sr_n      = sr;
        cnt_n     = cnt;
        q_n       = q;
        q_valid_n = q_valid;
        sof_n     = sof;
        eof_n     = eof;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_n   = SHIFT;
                    sr_n      = advance(din);
                    cnt_n     = '0;
                    q_n       = first_bit(din);
                    q_valid_n = 1'b1;
                    sof_n     = 1'b1;
                    eof_n     = 1'b0;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (!last) begin
                        q_n   = first_bit(sr);
                        sr_n  = advance(sr);
                        cnt_n = cnt_inc;
                        sof_n = 1'b0;
                        eof_n = (cnt_inc == CNT_LAST);
                    end else if (accept) begin
                        // Back-to-back frame: no idle bubble between words.
                        sr_n      = advance(din);
                        cnt_n     = '0;
                        q_n       = first_bit(din);
                        q_valid_n = 1'b1;
                        sof_n     = 1'b1;
                        eof_n     = 1'b0;
                    end else begin
                        state_n   = IDLE;
                        sr_n      = '0;
                        cnt_n     = '0;
                        q_n       = 1'b0;
                        q_valid_n = 1'b0;
                        sof_n     = 1'b0;
                        eof_n     = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            q       <= 1'b0;
            q_valid <= 1'b0;
            sof     <= 1'b0;
            eof     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            sr      <= sr_n;
            cnt     <= cnt_n;
            q       <= q_n;
            q_valid <= q_valid_n;
            sof     <= sof_n;
            eof     <= eof_n;
            busy    <= busy_n;
        end
    end

endmodule

// File: tb/tb_piso_shifter.sv
// Directed bench for piso_shifter: an MSB-first and an LSB-first instance share
// stimulus; expected bit sequences are hand-computed per scenario.
module tb_piso_shifter;

    logic       clk = 1'b0;
    logic       rst, load, en;
    logic [3:0] din;
    logic       m_ready, m_q, m_qv, m_sof, m_eof, m_busy;
    logic       l_ready, l_q, l_qv, l_sof, l_eof, l_busy;
    int         errs   = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    piso_shifter #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .din(din), .load(load), .ready(m_ready), .en(en),
        .q(m_q), .q_valid(m_qv), .sof(m_sof), .eof(m_eof), .busy(m_busy)
    );

    piso_shifter #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .din(din), .load(load), .ready(l_ready), .en(en),
        .q(l_q), .q_valid(l_qv), .sof(l_sof), .eof(l_eof), .busy(l_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance one edge and check the MSB-first instance's frame outputs.
    task automatic step_chk(input string tag, input logic eq, input logic eqv,
                            input logic esof, input logic eeof);
        step();
        chk({tag, ".q"},   m_q,   eq);
        chk({tag, ".qv"},  m_qv,  eqv);
        chk({tag, ".sof"}, m_sof, esof);
        chk({tag, ".eof"}, m_eof, eeof);
    endtask

    initial begin
        logic [7:0] bb;
        rst = 1'b1; load = 1'b1; din = 4'hF; en = 1'b1;

        // Reset held for 3 edges with a load pending
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rst%0d.q", i),     m_q,     1'b0);
            chk($sformatf("rst%0d.qv", i),    m_qv,    1'b0);
            chk($sformatf("rst%0d.sof", i),   m_sof,   1'b0);
            chk($sformatf("rst%0d.eof", i),   m_eof,   1'b0);
            chk($sformatf("rst%0d.busy", i),  m_busy,  1'b0);
            chk($sformatf("rst%0d.ready", i), m_ready, 1'b0);
        end
        rst = 1'b0; load = 1'b0;
        #1;
        chk("post_rst.ready", m_ready, 1'b1);
        step();
        chk("post_rst.qv", m_qv, 1'b0);
        chk("post_rst.ready2", m_ready, 1'b1);

        // Single frame 1011: MSB 1,0,1,1 and LSB 1,1,0,1
        din = 4'b1011; load = 1'b1;
        step_chk("sf0", 1'b1, 1'b1, 1'b1, 1'b0);
        chk("sf0.lq", l_q, 1'b1);
        chk("sf0.busy", m_busy, 1'b1);
        chk("sf0.lsof", l_sof, 1'b1);
        load = 1'b0;
        step_chk("sf1", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("sf1.lq", l_q, 1'b1);
        chk("sf1.ready", m_ready, 1'b0);
        step_chk("sf2", 1'b1, 1'b1, 1'b0, 1'b0);
        chk("sf2.lq", l_q, 1'b0);
        step_chk("sf3", 1'b1, 1'b1, 1'b0, 1'b1);
        chk("sf3.lq", l_q, 1'b1);
        chk("sf3.leof", l_eof, 1'b1);
        chk("sf3.ready", m_ready, 1'b1);
        step_chk("sf_end", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sf_end.ready", m_ready, 1'b1);
        chk("sf_end.busy", m_busy, 1'b0);

        // Back-to-back 1000 then 0110 with load held high
        bb = 8'b1000_0110;
        din = 4'b1000; load = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step_chk($sformatf("bb%0d", i), bb[7-i], 1'b1, (i % 4) == 0, (i % 4) == 3);
            if (i == 0) din = 4'b0110;
            if (i == 4) load = 1'b0;
        end
        step_chk("bb_end", 1'b0, 1'b0, 1'b0, 1'b0);

        // Stall after bit 0 of 1001 with a mid-frame load of F
        din = 4'b1001; load = 1'b1;
        step_chk("st0", 1'b1, 1'b1, 1'b1, 1'b0);
        en = 1'b0; din = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("st_hold%0d.ready", i), m_ready, 1'b0);
            step_chk($sformatf("st_hold%0d", i), 1'b1, 1'b1, 1'b1, 1'b0);
            load = 1'b0;
        end
        load = 1'b1; #1;
        chk("st_ign.ready", m_ready, 1'b0);
        step();                                    // en still low; load dropped next
        load = 1'b0; en = 1'b1;
        chk("st_hold3.q", m_q, 1'b1);
        step_chk("st1", 1'b0, 1'b1, 1'b0, 1'b0);
        step_chk("st2", 1'b0, 1'b1, 1'b0, 1'b0);
        step_chk("st3", 1'b1, 1'b1, 1'b0, 1'b1);
        step_chk("st_end", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("st_end.busy", m_busy, 1'b0);

        // Abort mid-frame of 1111, then a clean 0101 frame
        din = 4'b1111; load = 1'b1;
        step_chk("ab0", 1'b1, 1'b1, 1'b1, 1'b0);
        load = 1'b0;
        step_chk("ab1", 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("ab_rst.ready", m_ready, 1'b0);
        step_chk("ab_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ab_rst.busy", m_busy, 1'b0);
        rst = 1'b0; din = 4'b0101; load = 1'b1;
        step_chk("fr0", 1'b0, 1'b1, 1'b1, 1'b0);
        load = 1'b0;
        step_chk("fr1", 1'b1, 1'b1, 1'b0, 1'b0);
        step_chk("fr2", 1'b0, 1'b1, 1'b0, 1'b0);
        step_chk("fr3", 1'b1, 1'b1, 1'b0, 1'b1);
        step_chk("fr_end", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/piso_shifter.md
# piso_shifter

Parallel-in, serial-out shifter. It accepts a WIDTH-bit word through a ready/load handshake and emits it one bit per enabled clock on a serial line, with valid, start-of-frame and end-of-frame markers. It is the transmit-side counterpart of the team's serial-in ring shifter: its serial output drives that block's d input, so a word loaded here reappears in parallel at the far end.

## Interface
- WIDTH, 4: word length in bits, ≥2.
- MSB_FIRST, 1: 1 = din[WIDTH-1] is sent first; 0 = din[0] is sent first.
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  parallel word; sampled only on an accepted load.
- load  input  1  load request; the word is accepted on an edge where load && ready.
- ready  output  1  combinational: !rst && (state==IDLE || (state==SHIFT && last && en)).
- en  input  1  shift enable; when low in SHIFT, all registers hold.
- q  output  1  registered serial data bit.
- q_valid  output  1  registered; high while q carries a frame bit.
- sof  output  1  registered; high with the first bit of a frame.
- eof  output  1  registered; high with the last bit of a frame.
- busy  output  1  registered; equals (state==SHIFT).

## Operation
- Two states:
  - IDLE: q_valid=0, waiting for a load.
  - SHIFT: a frame is being emitted.
- Registers:
  - shift register sr[WIDTH-1:0].
  - bit counter cnt, width $clog2(WIDTH), range 0..WIDTH-1.
  - last = (cnt==WIDTH-1).
- Reset (edge with rst=1):
  - state=IDLE, sr=0, cnt=0, q=0, q_valid=0, sof=0, eof=0, busy=0.
  - rst has priority over load and en.
- IDLE with load accepted:
  - state→SHIFT, cnt=0, sof=1, q_valid=1, eof=0.
  - q = first bit: din[WIDTH-1] if MSB_FIRST, else din[0].
  - sr holds the remaining bits.
  - en is ignored in IDLE; loading does not need en.
- SHIFT with en=1 and !last:
  - q = next bit from sr; cnt+1; sof=0.
  - eof=1 when the new cnt == WIDTH-1.
- SHIFT with en=1 and last:
  - If load=1 (ready is high): accept the new word back-to-back with no bubble. Behaves as the IDLE accept: cnt=0, sof=1, eof=0, stay in SHIFT.
  - Else: state→IDLE, q_valid=0, sof=0, eof=0, q=0.
- SHIFT with en=0:
  - q, q_valid, sof, eof, sr and cnt all hold; ready=0.
  - A load while en=0 is not accepted and is not remembered.
- A load in SHIFT when !last is ignored; the current frame is never corrupted.
- rst asserted mid-frame aborts the frame. Outputs take reset values at that edge; the remaining bits are discarded.

## Timing
- Latency: word accepted at edge N → first bit on q after edge N. Bit k (0-based) appears after edge N+k, counting enabled edges only.
- Frame length: exactly WIDTH enabled cycles with q_valid=1.
  - sof is high on bit 0 only; eof is high on bit WIDTH-1 only.
  - Both are high together only if WIDTH=1, which is excluded.
- Throughput: with load held high and en=1, one word per WIDTH cycles. q_valid stays continuously high across frames.
- ready rises combinationally in the last-bit cycle of a frame when en=1. It is high in every IDLE cycle when rst=0.
- Cycle after reset release: IDLE, ready=1, q_valid=0.

## Test plan
- Reset: hold rst for 3 edges with load=1 and din=4'hF → q=0, q_valid=0, sof=0, eof=0, busy=0, and ready=0 while rst is high. After release, ready=1.
- Single frame, MSB_FIRST=1, din=4'b1011, en=1 → q=1,0,1,1 on 4 consecutive cycles. sof on the 1st bit, eof on the 4th. Next cycle q_valid=0, ready=1.
- LSB-first: MSB_FIRST=0, din=4'b1011 → q=1,1,0,1.
- Back-to-back: load held high with 4'b1000 then 4'b0110 → q=1,0,0,0,0,1,1,0. q_valid high for 8 straight cycles; sof on cycles 1 and 5; eof on cycles 4 and 8.
- Stall and ignore: send 4'b1001, drop en for 3 cycles after bit 1, and pulse load with 4'hF mid-frame → outputs frozen during the stall, sequence still 1,0,0,1, 4'hF never emitted.
- Abort: assert rst after bit 2 of 4'b1111 → next cycle q=0, q_valid=0, busy=0. A fresh load of 4'b0101 then yields 0,1,0,1.
